// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA field bounds, jump opcodes and fetch-state encoding
package isa_pkg;

  localparam int INSTR_W = 19;
  localparam int OP_MSB  = 18;
  localparam int OP_LSB  = 15;

  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_JNZ = 4'b1001;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

  function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
    return (instr[OP_MSB:OP_LSB] == OP_JZ) || (instr[OP_MSB:OP_LSB] == OP_JNZ);
  endfunction

endpackage

// File: rtl/ifu_queue.sv
// rtl/ifu_queue.sv - DEPTH-entry shift FIFO of {instr, pc} with sync flush and count
module ifu_queue #(
  parameter  int DEPTH = 1,
  parameter  int W     = 27,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem   [DEPTH];
  logic [W-1:0]     mem_n [DEPTH];
  logic [CNT_W-1:0] cnt_n;

  // Entry 0 is always the head; a pop shifts the rest down before the push lands.
  always_comb begin
    mem_n = mem;
    cnt_n = count;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
      cnt_n = count - CNT_W'(1);
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == cnt_n) mem_n[i] = wdata;
      end
      cnt_n = cnt_n + CNT_W'(1);
    end
    if (flush) cnt_n = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= cnt_n;
      mem   <= mem_n;
    end
  end

  assign rdata = mem[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, single-outstanding imem fetch FSM and prefetch queue
// IFU_PREFETCH_EN selects a 2-entry queue; default build uses a single entry.
module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = isa_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] pline,
  output logic [PC_W-1:0]    pline_pc,
  output logic               pline_valid,
  input  logic               pline_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc
);
  import isa_pkg::*;

`ifdef IFU_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = INSTR_W + PC_W;

  fetch_state_t     state;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] cnt_after_pop;
  logic [ENT_W-1:0] q_head;
  logic             pop;
  logic             push;
  logic             room_idle;
  logic             room_after_push;

  assign pline_valid     = (q_count != '0);
  assign pop             = pline_valid && pline_ready;
  assign push            = (state == FETCH_REQ) && imem_ack && !redirect;
  assign cnt_after_pop   = q_count - CNT_W'(pop);
  assign room_idle       = cnt_after_pop < CNT_W'(DEPTH);
  assign room_after_push = (cnt_after_pop + CNT_W'(1)) < CNT_W'(DEPTH);

  assign pline    = pline_valid ? q_head[ENT_W-1:PC_W] : '0;
  assign pline_pc = pline_valid ? q_head[PC_W-1:0]     : '0;

  ifu_queue #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({imem_rdata, imem_addr}),
    .pop   (pop),
    .flush (redirect),
    .rdata (q_head),
    .count (q_count)
  );

  // imem_addr only moves on an ack (or from IDLE), so it is stable while un-acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      pc        <= RESET_PC;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (room_idle) begin
            state     <= FETCH_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        FETCH_REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (imem_ack) imem_addr <= redirect_pc;
            else          state     <= FETCH_DROP;
          end else if (imem_ack) begin
            pc <= imem_addr + PC_W'(1);
            if (room_after_push) begin
              imem_addr <= imem_addr + PC_W'(1);
            end else begin
              state    <= FETCH_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        FETCH_DROP: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (imem_ack) begin
              state     <= FETCH_REQ;
              imem_addr <= redirect_pc;
            end
          end else if (imem_ack) begin
            state     <= FETCH_REQ;
            imem_addr <= pc;
          end
        end
        default: begin
          state    <= FETCH_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed table and corner-sequence bench for instr_fetch_unit
module tb_instr_fetch_unit;

`ifdef IFU_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, pline_valid, pline_ready, redirect;
  logic [7:0]  imem_addr, pline_pc, redirect_pc;
  logic [18:0] imem_rdata, pline;

  logic        imem_req2, imem_ack2, pline_valid2;
  logic        pline_ready2 = 1'b1;
  logic        redirect2 = 1'b0;
  logic [7:0]  imem_addr2, pline_pc2;
  logic [7:0]  redirect_pc2 = 8'h00;
  logic [18:0] imem_rdata2, pline2;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  int waitc = 0;
  int n_ack = 0;
  int n_acc = 0;
  int n2 = 0;
  logic [7:0] sb_exp = 8'h00;
  logic [7:0] last_acc = 8'h00;
  logic       prev_req = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic       rst_evt = 1'b0;
  logic [7:0] log2 [3];
  logic       data_ok2 [3];

  typedef struct {
    logic       req;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] ppc;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  instr_fetch_unit u_dut (
    .clk (clk), .rst_n (rst_n),
    .imem_req (imem_req), .imem_addr (imem_addr), .imem_ack (imem_ack), .imem_rdata (imem_rdata),
    .pline (pline), .pline_pc (pline_pc), .pline_valid (pline_valid), .pline_ready (pline_ready),
    .redirect (redirect), .redirect_pc (redirect_pc)
  );

  instr_fetch_unit #(.RESET_PC (8'hFE)) u_dut2 (
    .clk (clk), .rst_n (rst_n),
    .imem_req (imem_req2), .imem_addr (imem_addr2), .imem_ack (imem_ack2), .imem_rdata (imem_rdata2),
    .pline (pline2), .pline_pc (pline_pc2), .pline_valid (pline_valid2), .pline_ready (pline_ready2),
    .redirect (redirect2), .redirect_pc (redirect_pc2)
  );

  function automatic logic [18:0] img(input logic [7:0] a);
    return {3'b101, a, ~a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int lat, input logic rdy);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    pline_ready = rdy;
    mem_lat     = lat;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb_exp = 8'h00;
    n_acc  = 0;
    rst_n  = 1'b1;
  endtask

  task automatic wait_req_addr(input logic [7:0] a, input int max, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      step(1);
      if (imem_req && imem_addr == a) found = 1'b1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  // Program memory for u_dut: acks after mem_lat waiting cycles per request.
  always @(negedge clk) begin
    if (!rst_n || !imem_req) begin
      imem_ack = 1'b0;
      waitc    = 0;
    end else begin
      if (imem_ack) waitc = 0;
      if (waitc >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = img(imem_addr);
      end else begin
        imem_ack = 1'b0;
        waitc++;
      end
    end
  end

  // Program memory for u_dut2 acks in the request cycle; log its first three words.
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_ack2 = 1'b0;
      n2        = 0;
    end else begin
      imem_ack2   = imem_req2;
      imem_rdata2 = img(imem_addr2);
      if (pline_valid2 && n2 < 3) begin
        log2[n2]     = pline_pc2;
        data_ok2[n2] = (pline2 == img(pline_pc2));
        n2++;
      end
    end
  end

  // Decoder-side scoreboard: every accepted word is the next expected pc with its image data.
  always @(negedge clk) begin
    if (rst_n && pline_valid && pline_ready) begin
      check("accept_pc", 32'(pline_pc), 32'(sb_exp));
      check("accept_data", 32'(pline), 32'(img(pline_pc)));
      last_acc = pline_pc;
      n_acc++;
      sb_exp = pline_pc + 8'd1;
    end
  end

  always @(negedge rst_n) rst_evt = 1'b1;

  // Request hold: an un-acked request keeps imem_req and imem_addr across the edge.
  always @(posedge clk) begin
    #1;
    if (rst_evt || !rst_n) begin
      rst_evt  = 1'b0;
      prev_req = 1'b0;
      n_ack    = 0;
    end else begin
      if (prev_req && imem_ack) n_ack++;
      if (prev_req && !imem_ack) begin
        check("hold_req", 32'(imem_req), 32'd1);
        check("hold_addr", 32'(imem_addr), 32'(prev_addr));
      end
      prev_req  = imem_req;
      prev_addr = imem_addr;
    end
  end

  initial begin
    int n_before;
    logic got;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    pline_ready = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    imem_ack2   = 1'b0;
    imem_rdata2 = '0;

`ifdef IFU_PREFETCH_EN
    vecs[0] = '{1'b1, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'h01, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 8'h02, 1'b1, 8'h01};
    vecs[3] = '{1'b1, 8'h03, 1'b1, 8'h02};
    vecs[4] = '{1'b1, 8'h04, 1'b1, 8'h03};
    vecs[5] = '{1'b1, 8'h05, 1'b1, 8'h04};
`else
    vecs[0] = '{1'b1, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 8'h01, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 8'h01, 1'b1, 8'h01};
    vecs[4] = '{1'b1, 8'h02, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'h02, 1'b1, 8'h02};
`endif

    step(2);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h00);
    check("rst_valid", 32'(pline_valid), 32'd0);
    check("rst_pline", 32'(pline), 32'd0);
    check("rst_pline_pc", 32'(pline_pc), 32'd0);
    check("rst_addr2", 32'(imem_addr2), 32'hFE);

    // Free-running fetch, memory acks in the request cycle, decoder always ready.
    do_reset(0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d_valid", i), 32'(pline_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d_pc", i), 32'(pline_pc), 32'(vecs[i].ppc));
        check($sformatf("vec%0d_pline", i), 32'(pline), 32'(img(vecs[i].ppc)));
      end
    end

    // Reset pulse with a request in flight.
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (imem_req) got = 1'b1;
      else step(1);
    end
    check("midrst_req_seen", 32'(got), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'h00);
    check("midrst_valid", 32'(pline_valid), 32'd0);
    check("midrst_pline", 32'(pline), 32'd0);
    check("midrst_pline_pc", 32'(pline_pc), 32'd0);
    @(negedge clk);
    sb_exp = 8'h00;
    n_acc  = 0;
    rst_n  = 1'b1;
    step(1);
    check("midrst_restart_req", 32'(imem_req), 32'd1);
    check("midrst_restart_addr", 32'(imem_addr), 32'h00);

    // Decoder stall: fetch stops after DEPTH words, resumes without loss or duplication.
    do_reset(0, 1'b0);
    step(6);
    check("stall_acks", 32'(n_ack), 32'(DEPTH));
    check("stall_req", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(pline_valid), 32'd1);
    check("stall_pc", 32'(pline_pc), 32'h00);
    pline_ready = 1'b1;
    step(12);
    check("resume_progress", 32'(n_acc >= 5), 32'd1);

    // Redirect while 0x04 is outstanding, ack arrives later and is discarded.
    do_reset(3, 1'b1);
    wait_req_addr(8'h04, 60, "drop_find_04");
    redirect    = 1'b1;
    redirect_pc = 8'h1F;
    step(1);
    redirect = 1'b0;
    sb_exp   = 8'h1F;
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_addr", 32'(imem_addr), 32'h04);
    check("drop_valid", 32'(pline_valid), 32'd0);
    n_before = n_acc;
    wait_req_addr(8'h1F, 20, "drop_new_req_1f");
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1);
      if (n_acc > n_before) got = 1'b1;
    end
    check("drop_accept_seen", 32'(got), 32'd1);
    check("drop_first_pc", 32'(last_acc), 32'h1F);

    // Redirect to 0x10 in the same cycle as the ack of 0x03.
    do_reset(0, 1'b1);
    wait_req_addr(8'h03, 20, "rwa_find_03");
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    step(1);
    redirect = 1'b0;
    sb_exp   = 8'h10;
    check("rwa_req", 32'(imem_req), 32'd1);
    check("rwa_addr", 32'(imem_addr), 32'h10);
    check("rwa_valid_flushed", 32'(pline_valid), 32'd0);
    step(1);
    check("rwa_valid", 32'(pline_valid), 32'd1);
    check("rwa_pc", 32'(pline_pc), 32'h10);
    check("rwa_pline", 32'(pline), 32'(img(8'h10)));

    // RESET_PC=0xFE instance wraps its fetch address.
    step(4);
    check("wrap_count", 32'(n2), 32'd3);
    if (n2 == 3) begin
      check("wrap_pc0", 32'(log2[0]), 32'hFE);
      check("wrap_pc1", 32'(log2[1]), 32'hFF);
      check("wrap_pc2", 32'(log2[2]), 32'h00);
      check("wrap_data", 32'(data_ok2[0] && data_ok2[1] && data_ok2[2]), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
